// File: rtl/systolic_drain.sv
// Collects per-row result beats from the systolic array and turns them into banked memory writes.
// Latency: one cycle from an accepted beat to its bank write; done coincides with the final write.
// No backpressure: every valid beat is accepted in the cycle it arrives, because the array cannot stall.
module systolic_drain #(
  parameter int D_W_ACC    = 16,
  parameter int N1         = 4,
  parameter int N2         = 4,
  parameter int M          = 8,
  parameter int DROP_TILES = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [D_W_ACC-1:0]                D       [N1-1:0],
  input  logic [N1-1:0]                     valid_D,
  output logic [N1-1:0]                     wr_en,
  output logic [$clog2((M*M)/N1)-1:0]       wr_addr [N1-1:0],
  output logic [D_W_ACC-1:0]                wr_data [N1-1:0],
  output logic                              busy,
  output logic                              done,
  output logic                              err_overrun
);

  localparam int A_W   = $clog2((M*M)/N1);
  localparam int PIX   = M / N2;
  localparam int TILES = DROP_TILES + (M/N1)*(M/N2);
  localparam int C_W   = (N2 > 1) ? $clog2(N2) : 1;
  localparam int T_W   = (TILES > 1) ? $clog2(TILES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              state_q, state_d;

  // Per-row beat/tile counters and completion flags.
  logic [C_W-1:0]      c_q       [N1-1:0];
  logic [C_W-1:0]      c_d       [N1-1:0];
  logic [T_W-1:0]      t_q       [N1-1:0];
  logic [T_W-1:0]      t_d       [N1-1:0];
  logic [N1-1:0]       rdone_q, rdone_d;

  // Registered write port and status outputs.
  logic [N1-1:0]       wr_en_q, wr_en_d;
  logic [A_W-1:0]      wr_addr_q [N1-1:0];
  logic [A_W-1:0]      wr_addr_d [N1-1:0];
  logic [D_W_ACC-1:0]  wr_data_q [N1-1:0];
  logic [D_W_ACC-1:0]  wr_data_d [N1-1:0];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Per-row combinational helpers.
  logic [A_W-1:0]      k_a       [N1-1:0];
  logic [N1-1:0]       last_beat;
  logic [N1-1:0]       hit;
  logic                all_fin;

  // Per-row beat acceptance: counter stepping, kept-tile address generation, overrun detection.
  always_comb begin
    last_beat = '0;
    hit       = '0;
    rdone_d   = rdone_q;
    wr_en_d   = '0;
    for (int i = 0; i < N1; i++) begin
      c_d[i]       = c_q[i];
      t_d[i]       = t_q[i];
      wr_addr_d[i] = wr_addr_q[i];
      wr_data_d[i] = wr_data_q[i];
      // Index of the kept tile; only meaningful once the dropped tiles are past.
      k_a[i]       = A_W'(t_q[i]) - A_W'(DROP_TILES);
      if (start) begin
        // A beat coincident with start belongs to no run and is dropped.
        c_d[i]     = C_W'(N2-1);
        t_d[i]     = '0;
        rdone_d[i] = 1'b0;
      end else if (state_q == S_RUN && valid_D[i]) begin
        if (rdone_q[i]) begin
          hit[i] = 1'b1;
        end else begin
          if (32'(t_q[i]) >= 32'(DROP_TILES)) begin
            wr_en_d[i]   = 1'b1;
            // Stripe-major, pixel-minor; the column counter runs downward within a tile.
            wr_addr_d[i] = (k_a[i] / A_W'(PIX)) * A_W'(M)
                         + (k_a[i] % A_W'(PIX)) * A_W'(N2)
                         + A_W'(c_q[i]);
            wr_data_d[i] = D[i];
          end
          if (c_q[i] == '0) begin
            c_d[i] = C_W'(N2-1);
            if (t_q[i] == T_W'(TILES-1)) begin
              rdone_d[i]   = 1'b1;
              last_beat[i] = 1'b1;
            end else begin
              t_d[i] = t_q[i] + T_W'(1);
            end
          end else begin
            c_d[i] = c_q[i] - C_W'(1);
          end
        end
      end
    end
  end

  // Global FSM next state and next values of the status outputs.
  always_comb begin
    state_d = state_q;
    all_fin = &(rdone_q | last_beat);
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (start) state_d = S_RUN;
               else if (all_fin) state_d = S_FIN;
      S_FIN:   if (start) state_d = S_RUN;
               else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
    err_d  = start ? 1'b0 : (err_q | (|hit));
  end

  // FSM state and status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdone_q <= '0;
      wr_en_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdone_q <= rdone_d;
      wr_en_q <= wr_en_d;
    end
  end

  // Per-row counters and write address/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N1; i++) begin
        c_q[i]       <= '0;
        t_q[i]       <= '0;
        wr_addr_q[i] <= '0;
        wr_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N1; i++) begin
        c_q[i]       <= c_d[i];
        t_q[i]       <= t_d[i];
        wr_addr_q[i] <= wr_addr_d[i];
        wr_data_q[i] <= wr_data_d[i];
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: a reference model queues expected writes and status per cycle.
// Expected entries carry the cycle at which the DUT must show them; a monitor compares on the falling edge.
// Inputs are driven 1 time unit after the rising edge.
module tb_systolic_drain;
  localparam int D_W_ACC    = 16;
  localparam int N1         = 4;
  localparam int N2         = 4;
  localparam int M          = 8;
  localparam int DROP_TILES = 1;
  localparam int A_W        = $clog2((M*M)/N1);
  localparam int PIX        = M / N2;
  localparam int TILES      = DROP_TILES + (M/N1)*(M/N2);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [D_W_ACC-1:0]  d_in    [N1-1:0];
  logic [N1-1:0]       valid_D = '0;
  logic [N1-1:0]       wr_en;
  logic [A_W-1:0]      wr_addr [N1-1:0];
  logic [D_W_ACC-1:0]  wr_data [N1-1:0];
  logic                busy, done, err_overrun;

  systolic_drain #(
    .D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .M(M), .DROP_TILES(DROP_TILES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .D(d_in), .valid_D(valid_D),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int busy; int done; int err; } st_t;

  wr_t wq [N1][$];
  st_t sq [$];
  int  mem [N1][16];
  int  n_chk  = 0;
  int  n_fail = 0;

  // Reference model state.
  int  m_c  [N1];
  int  m_t  [N1];
  bit  m_rd [N1];
  bit  m_run = 0;
  bit  m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Falling-edge monitor: every cycle with a queued expectation is compared.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N1; i++) begin
        bit  exp_en;
        wr_t e;
        exp_en = (wq[i].size() > 0) && (wq[i][0].cyc == cyc);
        check_eq($sformatf("wr_en[%0d]", i), 32'(wr_en[i]), 32'(exp_en));
        if (wr_en[i] === 1'b1) mem[i][wr_addr[i]] = int'(wr_data[i]);
        if (exp_en) begin
          e = wq[i].pop_front();
          check_eq($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(e.addr));
          check_eq($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(e.data));
        end
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        st_t s;
        s = sq.pop_front();
        check_eq("busy", 32'(busy), 32'(s.busy));
        check_eq("done", 32'(done), 32'(s.done));
        check_eq("err_overrun", 32'(err_overrun), 32'(s.err));
      end
    end
  end

  // One clock of stimulus; the model predicts what the DUT shows one cycle later.
  task automatic tick(input logic st, input logic [N1-1:0] v);
    bit  fin;
    bit  all;
    int  k;
    wr_t w;
    st_t s;
    start   = st;
    valid_D = v;
    fin     = 0;
    if (st) begin
      m_run = 1;
      m_err = 0;
      for (int i = 0; i < N1; i++) begin
        m_c[i] = N2 - 1; m_t[i] = 0; m_rd[i] = 0;
      end
    end else if (m_run) begin
      for (int i = 0; i < N1; i++) begin
        if (v[i]) begin
          if (m_rd[i]) begin
            m_err = 1;
          end else begin
            if (m_t[i] >= DROP_TILES) begin
              k      = m_t[i] - DROP_TILES;
              w.cyc  = cyc + 1;
              w.addr = (k / PIX) * M + (k % PIX) * N2 + m_c[i];
              w.data = int'(d_in[i]);
              wq[i].push_back(w);
            end
            if (m_c[i] == 0) begin
              m_c[i] = N2 - 1;
              if (m_t[i] == TILES - 1) m_rd[i] = 1;
              else m_t[i] = m_t[i] + 1;
            end else begin
              m_c[i] = m_c[i] - 1;
            end
          end
        end
      end
      all = 1;
      for (int i = 0; i < N1; i++) all = all & m_rd[i];
      if (all) begin
        m_run = 0;
        fin   = 1;
      end
    end
    s.cyc = cyc + 1; s.busy = int'(m_run); s.done = int'(fin); s.err = int'(m_err);
    sq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Row beat streams: row 0 starts at offset 0, row i>0 at off_rest + i*skew; D = 16*row + beat index.
  task automatic stream(input logic [N1-1:0] mask, input int skew, input int nb0,
                        input int off_rest, input int nb_rest);
    int span, off, nb, b;
    logic [N1-1:0] v;
    span = nb0;
    if (off_rest + (N1-1)*skew + nb_rest > span) span = off_rest + (N1-1)*skew + nb_rest;
    for (int j = 0; j < span; j++) begin
      v = '0;
      for (int i = 0; i < N1; i++) begin
        off = (i == 0) ? 0 : off_rest + i*skew;
        nb  = (i == 0) ? nb0 : nb_rest;
        b   = j - off;
        if (mask[i] && b >= 0 && b < nb) begin
          v[i]    = 1'b1;
          d_in[i] = 16'(16*i + b);
        end else begin
          d_in[i] = 16'hEEEE;
        end
      end
      tick(1'b0, v);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < N1; i++) begin
      check_eq("rst_wr_en", 32'(wr_en[i]), 32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr[i]), 32'd0);
      check_eq("rst_wr_data", 32'(wr_data[i]), 32'd0);
      wq[i].delete();
    end
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err_overrun), 32'd0);
    sq.delete();
    m_run   = 0;
    m_err   = 0;
    start   = 1'b0;
    valid_D = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int left;
    for (int i = 0; i < N1; i++) d_in[i] = '0;

    // Reset, then beats without start must be ignored.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N1; i++) d_in[i] = 16'(100 + j);
      tick(1'b0, 4'hF);
    end
    tick(1'b0, '0);

    // Full matrix with one cycle of skew per row.
    tick(1'b1, '0);
    stream(4'hF, 1, 20, 0, 20);
    repeat (3) tick(1'b0, '0);
    for (int b = 0; b < N1; b++) begin
      check_eq($sformatf("bank%0d_a3", b),  32'(mem[b][3]),  32'(16*b + 4));
      check_eq($sformatf("bank%0d_a0", b),  32'(mem[b][0]),  32'(16*b + 7));
      check_eq($sformatf("bank%0d_a15", b), 32'(mem[b][15]), 32'(16*b + 16));
      check_eq($sformatf("bank%0d_a12", b), 32'(mem[b][12]), 32'(16*b + 19));
    end

    // Overrun: row 0 gets one beat too many while rows 1-3 are still draining.
    tick(1'b1, '0);
    stream(4'hF, 0, 21, 5, 20);
    repeat (2) tick(1'b0, '0);
    check_eq("err_sticky", 32'(err_overrun), 32'd1);

    // Restart mid-run after 7 beats on row 1.
    tick(1'b1, '0);
    stream(4'b0010, 0, 0, 0, 7);
    tick(1'b1, '0);
    stream(4'hF, 0, 20, 0, 20);
    repeat (2) tick(1'b0, '0);

    // Reset mid-run, then a clean full run.
    tick(1'b1, '0);
    stream(4'hF, 0, 10, 0, 10);
    do_reset();
    tick(1'b1, '0);
    stream(4'hF, 0, 20, 0, 20);
    repeat (2) tick(1'b0, '0);

    // Start coincident with a row-0 beat: that beat is dropped.
    d_in[0] = 16'h0BAD;
    tick(1'b1, 4'b0001);
    stream(4'hF, 1, 20, 0, 20);
    repeat (3) tick(1'b0, '0);

    #5;
    left = 0;
    for (int i = 0; i < N1; i++) left += wq[i].size();
    check_eq("writes_outstanding", 32'(left), 32'd0);
    check_eq("status_outstanding", 32'(sq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
